calc_sequencer: RTL

Central control FSM for the four-digit calculator. Sequences operand entry (number 1, then number 2), launches a multi-cycle arithmetic operation through a start/done handshake, latches and range-checks the result, and drives the display source select. Sits between the debounced button/slider front end and the operand registers, arithmetic unit and display multiplexer.

---
 rtl/calc_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/calc_sequencer.sv
// Central control FSM of the four-digit calculator: operand entry, ALU launch and
// completion handshake, result range check, error blink and display source select.
module calc_sequencer #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int BLINK_PERIOD   = 25000000,
   parameter int RESULT_MAX     = 9999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_ent,
   input  logic        btn_clr,
   input  logic [1:0]  op_sel,
   input  logic        alu_done,
   input  logic        alu_err,
   input  logic [13:0] alu_result,
   output logic        write_sel,
   output logic        operand_clr,
   output logic        alu_start,
   output logic [1:0]  alu_op,
   output logic [13:0] result,
   output logic [1:0]  display_sel,
   output logic        busy,
   output logic        err_blink
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int BW = $clog2(BLINK_PERIOD + 1);
   // WAIT gives up on the edge where its count would reach TIMEOUT_CYCLES-1,
   // so ERROR shows up exactly TIMEOUT_CYCLES cycles after alu_start.
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 2);
   localparam logic [BW-1:0] BL_LAST = BW'(BLINK_PERIOD - 1);
   localparam logic [13:0]   RES_MAX = 14'(RESULT_MAX);

   typedef enum logic [2:0] {
      S_ENTER_A = 3'd0,
      S_ENTER_B = 3'd1,
      S_START   = 3'd2,
      S_WAIT    = 3'd3,
      S_SHOW    = 3'd4,
      S_ERROR   = 3'd5
   } state_t;

   state_t          state_r, next_state_s;
   logic [TW-1:0]   to_cnt_r, to_cnt_s;
   logic [BW-1:0]   blink_cnt_r, blink_cnt_s;
   logic            op_clr_s, alu_start_s, busy_s, write_sel_s, err_blink_s;
   logic [1:0]      alu_op_s, display_sel_s;
   logic [13:0]     result_s;

   // Next-state, counter and output computation; outputs decode from the next state.
   always_comb begin
      next_state_s = state_r;
      to_cnt_s     = to_cnt_r;
      blink_cnt_s  = blink_cnt_r;
      err_blink_s  = err_blink;
      op_clr_s     = 1'b0;
      alu_op_s     = alu_op;
      result_s     = result;

      case (state_r)
         S_ENTER_A: begin
            if (btn_clr) begin
               op_clr_s = 1'b1;
            end else if (btn_ent) begin
               next_state_s = S_ENTER_B;
            end else begin
               next_state_s = S_ENTER_A;
            end
         end
         S_ENTER_B: begin
            if (btn_clr) begin
               op_clr_s     = 1'b1;
               next_state_s = S_ENTER_A;
            end else if (btn_ent) begin
               alu_op_s     = op_sel;
               next_state_s = S_START;
            end else begin
               next_state_s = S_ENTER_B;
            end
         end
         S_START: begin
            to_cnt_s     = {TW{1'b0}};
            next_state_s = S_WAIT;
         end
         S_WAIT: begin
            // Abort beats a coincident completion: the result is not taken.
            if (btn_clr) begin
               op_clr_s     = 1'b1;
               next_state_s = S_ENTER_A;
            end else if (alu_done) begin
               if (alu_err || (alu_result > RES_MAX)) begin
                  next_state_s = S_ERROR;
               end else begin
                  result_s     = alu_result;
                  next_state_s = S_SHOW;
               end
            end else if (to_cnt_r == TO_LAST) begin
               next_state_s = S_ERROR;
            end else begin
               to_cnt_s = to_cnt_r + TW'(1);
            end
         end
         S_SHOW: begin
            if (btn_clr) begin
               op_clr_s     = 1'b1;
               next_state_s = S_ENTER_A;
            end else if (btn_ent) begin
               next_state_s = S_ENTER_A;
            end else begin
               next_state_s = S_SHOW;
            end
         end
         S_ERROR: begin
            if (btn_clr || btn_ent) begin
               op_clr_s     = 1'b1;
               blink_cnt_s  = {BW{1'b0}};
               err_blink_s  = 1'b0;
               next_state_s = S_ENTER_A;
            end else if (blink_cnt_r == BL_LAST) begin
               blink_cnt_s = {BW{1'b0}};
               err_blink_s = ~err_blink;
            end else begin
               blink_cnt_s = blink_cnt_r + BW'(1);
            end
         end
         default: begin
            next_state_s = S_ENTER_A;
         end
      endcase

      alu_start_s = (next_state_s == S_START);
      busy_s      = (next_state_s == S_START) || (next_state_s == S_WAIT);
      write_sel_s = (next_state_s != S_ENTER_A);

      case (next_state_s)
         S_ENTER_A: display_sel_s = 2'd0;
         S_ENTER_B: display_sel_s = 2'd1;
         S_START:   display_sel_s = 2'd1;
         S_WAIT:    display_sel_s = 2'd1;
         S_SHOW:    display_sel_s = 2'd2;
         S_ERROR:   display_sel_s = 2'd3;
         default:   display_sel_s = 2'd0;
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= S_ENTER_A;
         to_cnt_r    <= {TW{1'b0}};
         blink_cnt_r <= {BW{1'b0}};
         write_sel   <= 1'b0;
         operand_clr <= 1'b0;
         alu_start   <= 1'b0;
         alu_op      <= 2'd0;
         result      <= 14'd0;
         display_sel <= 2'd0;
         busy        <= 1'b0;
         err_blink   <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         to_cnt_r    <= to_cnt_s;
         blink_cnt_r <= blink_cnt_s;
         write_sel   <= write_sel_s;
         operand_clr <= op_clr_s;
         alu_start   <= alu_start_s;
         alu_op      <= alu_op_s;
         result      <= result_s;
         display_sel <= display_sel_s;
         busy        <= busy_s;
         err_blink   <= err_blink_s;
      end
   end

endmodule
